bist_sequencer: RTL and testbench
=================================

// Module: bist_sequencer
// PURPOSE
// - Top-level BIST run controller for the ALU self-test. It sequences the test pattern generator (TPG),
//   the CUT_ALU and the 74-bit MISR through init, pattern run, pipeline flush and compare phases.
// - It compares the final MISR signature against a golden constant and reports pass/fail to the test host.
// PARAMETERS
// - SIG_W          74      MISR signature width
// - INIT_CYCLES    2       cycles test_reset is held before patterns start (>=1)
// - PATTERN_COUNT  256     number of TPG patterns applied (>=1)
// - FLUSH_CYCLES   3       extra MISR clocks after TPG stops, covering CUT regs, shifter stage and MISR reg (>=1)
// - GOLDEN         74'h0   expected signature; overridden per build
// - CNT_W          16      width of the shared phase counter; must hold max(INIT_CYCLES,PATTERN_COUNT,FLUSH_CYCLES)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - start        in   1      single-cycle request to begin a run
// - misr_sig     in   SIG_W  current MISR register value
// - test_reset   out  1      synchronous reset to the TPG, CUT and MISR
// - tpg_en       out  1      advance the TPG one pattern per cycle
// - misr_en      out  1      MISR/CUT clock enable (compaction active)
// - busy         out  1      high in every state except IDLE and DONE
// - done         out  1      level; run complete, result valid
// - pass         out  1      valid only while done=1; 1 = signature matched GOLDEN
// - signature    out  SIG_W  signature captured in COMPARE; held until the next run
// - abort        in   1      present only with BIST_ABORT_EN
// BEHAVIOUR
// - Clock and reset: reset reset, synchronous, active-high; clock clk.
// - Reset values: all outputs 0; signature 0; state IDLE; counter 0.
//   A reset mid-run returns to IDLE on the next edge with no done pulse.
// - State machine: IDLE -> INIT -> RUN -> FLUSH -> COMPARE -> DONE. All outputs are registered.
// - IDLE
//   - start=1 -> INIT; counter loaded with 0.
// - INIT
//   - test_reset=1, busy=1.
//   - Stays INIT_CYCLES cycles, then -> RUN.
// - RUN
//   - tpg_en=1, misr_en=1, busy=1.
//   - Stays exactly PATTERN_COUNT cycles, then -> FLUSH.
// - FLUSH
//   - tpg_en=0, misr_en=1, busy=1.
//   - Stays FLUSH_CYCLES cycles, then -> COMPARE.
// - COMPARE
//   - One cycle, busy=1, misr_en=0.
//   - signature<=misr_sig; pass<=(misr_sig==GOLDEN). Then -> DONE.
// - DONE
//   - done=1, busy=0; pass and signature held.
//   - start=1 -> INIT: done and pass clear on that edge.
// - Latency: from the edge that samples start to the first cycle of done is
//   INIT_CYCLES+PATTERN_COUNT+FLUSH_CYCLES+2 cycles.
// - start while busy=1 is ignored (not queued). start and reset together: reset wins.
// - Counter: single CNT_W up-counter, cleared on every state change.
//   Terminal compare is count==N-1, so no wrap-around can occur.
// - Parameters equal to 0 are illegal and are rejected at elaboration by a generate-time $error.
// CONFIGURATION
// - BIST_ABORT_EN defined:
//   - abort port exists.
//   - abort=1 in INIT/RUN/FLUSH/COMPARE -> DONE on the next edge with pass=0 and signature unchanged.
//   - abort in IDLE/DONE has no effect. abort and start together in DONE: abort ignored, run starts.
// - BIST_ABORT_EN undefined: no abort port; the run always completes.
// TESTING
// - Use INIT_CYCLES=2, PATTERN_COUNT=16, FLUSH_CYCLES=3, GOLDEN=74'h1234.
// - Good run: start pulse at cycle 0, misr_sig driven to 74'h1234 during COMPARE
//   -> test_reset high cycles 1-2, tpg_en high cycles 3-18, misr_en high cycles 3-21,
//      done=1 and pass=1 from cycle 23, signature=74'h1234.
// - Bad signature: same stimulus with misr_sig=74'h1235 -> done=1 at cycle 23, pass=0, signature=74'h1235.
// - Start while busy: extra start pulses at cycles 5 and 10 -> timing identical to the good run,
//   single done at cycle 23.
// - Reset mid-run: reset at cycle 8 -> cycle 9 all outputs 0, state IDLE;
//   a new start at cycle 12 gives done at cycle 35.
// - Rerun from DONE: start at cycle 30 -> done and pass drop at cycle 31, test_reset high cycles 31-32,
//   done again at cycle 53.
// - With BIST_ABORT_EN: abort at cycle 10 -> done=1, pass=0, busy=0 at cycle 11; tpg_en and misr_en low.

Source files
------------

// File: rtl/bist_sequencer.sv
// bist_sequencer: run controller for the ALU self-test.
// Sequences TPG, CUT and MISR through INIT -> RUN -> FLUSH -> COMPARE -> DONE
// and reports the MISR signature against GOLDEN.
// Optional feature macro: BIST_ABORT_EN (adds the abort input).
module bist_sequencer #(
  parameter int                SIG_W         = 74,
  parameter int                INIT_CYCLES   = 2,
  parameter int                PATTERN_COUNT = 256,
  parameter int                FLUSH_CYCLES  = 3,
  parameter logic [SIG_W-1:0]  GOLDEN        = {SIG_W{1'b0}},
  parameter int                CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SIG_W-1:0] misr_sig,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  output logic             test_reset,
  output logic             tpg_en,
  output logic             misr_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Terminal counts: each phase ends when the counter reaches N-1.
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Zero-length phases would make the terminal compare wrap; refuse them.
  if (INIT_CYCLES < 1 || PATTERN_COUNT < 1 || FLUSH_CYCLES < 1) begin : g_bad_param
    $error("bist_sequencer: INIT_CYCLES, PATTERN_COUNT and FLUSH_CYCLES must be >= 1");
  end

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt;
  logic [SIG_W-1:0]   w_sig;
  logic               w_pass;
  logic               w_abort;

`ifdef BIST_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Next-state, counter and result logic; outputs are derived from the next state.
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt + CNT_ONE;
    w_sig  = signature;
    w_pass = pass;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_INIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_INIT: begin
        if (w_abort) begin
          w_next = S_DONE;
          w_pass = 1'b0;
        end else if (r_cnt == INIT_LAST) begin
          w_next = S_RUN;
        end else begin
          w_next = S_INIT;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_next = S_DONE;
          w_pass = 1'b0;
        end else if (r_cnt == RUN_LAST) begin
          w_next = S_FLUSH;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FLUSH: begin
        if (w_abort) begin
          w_next = S_DONE;
          w_pass = 1'b0;
        end else if (r_cnt == FLUSH_LAST) begin
          w_next = S_COMPARE;
        end else begin
          w_next = S_FLUSH;
        end
      end
      S_COMPARE: begin
        w_next = S_DONE;
        if (w_abort) begin
          w_pass = 1'b0;
        end else begin
          w_sig  = misr_sig;
          w_pass = (misr_sig == GOLDEN);
        end
      end
      S_DONE: begin
        if (start) begin
          w_next = S_INIT;
          w_pass = 1'b0;
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
        w_pass = 1'b0;
      end
    endcase
    // Counter restarts on every state change and stays at zero in IDLE.
    if (w_next != r_state || r_state == S_IDLE) begin
      w_cnt = {CNT_W{1'b0}};
    end else begin
      w_cnt = w_cnt;
    end
  end

  // State, counter and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      test_reset <= 1'b0;
      tpg_en     <= 1'b0;
      misr_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= {SIG_W{1'b0}};
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      test_reset <= (w_next == S_INIT);
      tpg_en     <= (w_next == S_RUN);
      misr_en    <= (w_next == S_RUN) || (w_next == S_FLUSH);
      busy       <= (w_next == S_INIT) || (w_next == S_RUN) ||
                    (w_next == S_FLUSH) || (w_next == S_COMPARE);
      done       <= (w_next == S_DONE);
      pass       <= w_pass;
      signature  <= w_sig;
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Randomized bench for bist_sequencer against a cycle-offset reference model.
module tb_bist_sequencer;

  localparam int               SIG_W  = 74;
  localparam int               INIT_C = 2;
  localparam int               PAT_C  = 16;
  localparam int               FL_C   = 3;
  localparam logic [SIG_W-1:0] GOLD   = 74'h1234;
  localparam int               T_CMP  = INIT_C + PAT_C + FL_C + 1;

  logic             clk = 1'b0;
  logic             reset, start, abort_v;
  logic [SIG_W-1:0] misr_sig;
  logic             test_reset, tpg_en, misr_en, busy, done, pass;
  logic [SIG_W-1:0] signature;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bist_sequencer #(
    .SIG_W(SIG_W), .INIT_CYCLES(INIT_C), .PATTERN_COUNT(PAT_C),
    .FLUSH_CYCLES(FL_C), .GOLDEN(GOLD), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .misr_sig(misr_sig),
`ifdef BIST_ABORT_EN
    .abort(abort_v),
`endif
    .test_reset(test_reset), .tpg_en(tpg_en), .misr_en(misr_en),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a run is described by the number of edges since start was taken.
  bit               m_active;
  int               m_off;
  bit               m_done, m_pass;
  logic [SIG_W-1:0] m_sig;
  int               n_pass_runs = 0;
  int               n_fail_runs = 0;

  initial begin
    logic [95:0] rnd;
    logic [5:0]  flags_exp;
    m_active = 1'b0; m_off = 0; m_done = 1'b0; m_pass = 1'b0; m_sig = '0;
    reset = 1'b1; start = 1'b0; abort_v = 1'b0; misr_sig = '0;
    for (int i = 0; i < 4000; i++) begin
      // Drive inputs for this cycle.
      reset = (i < 3) || ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0) || (i == 3);
`ifdef BIST_ABORT_EN
      abort_v = ($urandom_range(0, 79) == 0);
`else
      abort_v = 1'b0;
`endif
      case ($urandom_range(0, 3))
        0, 1: misr_sig = GOLD;
        2: misr_sig = GOLD ^ (74'h1 << $urandom_range(0, SIG_W - 1));
        default: begin
          rnd = {$urandom(), $urandom(), $urandom()};
          misr_sig = rnd[SIG_W-1:0];
        end
      endcase
      @(posedge clk);
      cyc = i;
      // Model update for this edge.
      if (reset) begin
        m_active = 1'b0; m_off = 0; m_done = 1'b0; m_pass = 1'b0; m_sig = '0;
      end else if (m_active) begin
        if (abort_v) begin
          m_active = 1'b0; m_done = 1'b1; m_pass = 1'b0;
        end else if (m_off == T_CMP) begin
          m_sig = misr_sig; m_pass = (misr_sig == GOLD);
          m_done = 1'b1; m_active = 1'b0;
          if (m_pass) n_pass_runs++; else n_fail_runs++;
        end else begin
          m_off++;
        end
      end else if (start) begin
        m_active = 1'b1; m_off = 1; m_done = 1'b0; m_pass = 1'b0;
      end
      @(negedge clk);
      flags_exp[5] = m_active && (m_off <= INIT_C);
      flags_exp[4] = m_active && (m_off > INIT_C) && (m_off <= INIT_C + PAT_C);
      flags_exp[3] = m_active && (m_off > INIT_C) && (m_off <= INIT_C + PAT_C + FL_C);
      flags_exp[2] = m_active;
      flags_exp[1] = m_done;
      flags_exp[0] = m_pass;
      check_val("flags{trst,tpg,misr,busy,done,pass}",
                {122'd0, test_reset, tpg_en, misr_en, busy, done, pass},
                {122'd0, flags_exp});
      check_val("signature", {54'd0, signature}, {54'd0, m_sig});
    end
    check_val("passing_runs_seen", {127'd0, (n_pass_runs > 0)}, {127'd0, 1'b1});
    check_val("failing_runs_seen", {127'd0, (n_fail_runs > 0)}, {127'd0, 1'b1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
